bcd_to_bin: RTL and testbench

- Sequential BCD-to-binary converter; the inverse of the combinational binary-to-BCD block feeding the 7-seg display path.
- Takes DIGITS packed BCD digits, most significant digit in the top nibble.
- Produces the unsigned binary value by reverse double-dabble: one shift per clock, start/done handshake.
- Sits between the keypad/BCD entry logic and the adder datapath.

---
 rtl/bcd_to_bin.sv | 124 ++++++++++++
 tb/tb_bcd_to_bin.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional invalid-digit check enabled by defining BCD_ERR_CHECK_EN.
module bcd_to_bin #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic [BIN_W-1:0]   bin_reg, bin_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [BIN_W-1:0]   bin_out_reg, bin_out_next;
    logic               err_reg, err_next;

    logic [WORK_W-1:0]  shifted;
    logic [BCD_W-1:0]   bcd_adj;

    // The bcd LSB drops into the bin MSB; each digit then gets its -3 correction.
    assign shifted = {bcd_reg, bin_reg} >> 1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = shifted[BIN_W + 4*gi +: 4];
            assign bcd_adj[4*gi +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
        end
    endgenerate

`ifdef BCD_ERR_CHECK_EN
    logic [DIGITS-1:0] digit_bad;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign digit_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
        end
    endgenerate
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            bcd_reg     <= '0;
            bin_reg     <= '0;
            cnt_reg     <= '0;
            bin_out_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bcd_reg     <= bcd_next;
            bin_reg     <= bin_next;
            cnt_reg     <= cnt_next;
            bin_out_reg <= bin_out_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bcd_next     = bcd_reg;
        bin_next     = bin_reg;
        cnt_next     = cnt_reg;
        bin_out_next = bin_out_reg;
        err_next     = err_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    bcd_next   = bcd_in;
                    bin_next   = '0;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                    state_next = SHIFT;
`ifdef BCD_ERR_CHECK_EN
                    if (|digit_bad) begin
                        err_next     = 1'b1;
                        bin_out_next = '0;
                        state_next   = DONE;
                    end
`endif
                end
            end
            SHIFT: begin
                bcd_next = bcd_adj;
                bin_next = shifted[BIN_W-1:0];
                cnt_next = cnt_reg + CNT_W'(1);
                // Result is loaded on entry to DONE so it is valid alongside the done pulse.
                if (cnt_reg == LAST_ITER) begin
                    bin_out_next = shifted[BIN_W-1:0];
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg == SHIFT);
    assign done    = (state_reg == DONE);
    assign bin_out = bin_out_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomized self-checking bench for bcd_to_bin (DIGITS=2, BIN_W=7) against
// an arithmetic decimal-value model.
module tb_bcd_to_bin;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] bcd_in;
    logic       busy;
    logic       done;
    logic [6:0] bin_out;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_to_bin #(.DIGITS(2), .BIN_W(7)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Decimal value of a packed BCD word, most significant digit first.
    function automatic int bcd_value(input logic [7:0] v);
        int acc = 0;
        for (int d = 1; d >= 0; d--) acc = acc * 10 + int'(v[4*d +: 4]);
        return acc;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    // One conversion: start is high for exactly one cycle (cycle 1); latency is
    // the index of the done cycle counting the start cycle as 1.
    task automatic convert(input string tag, input logic [7:0] v, input bit poke,
                           input int exp_lat, input int exp_busy,
                           input int exp_val, input bit exp_err);
        int cyc, busy_cnt, extra;
        logic [6:0] prev;
        bit moved;
        @(negedge clk);
        prev = bin_out;
        bcd_in = v;
        start = 1'b1;
        cyc = 1;
        busy_cnt = 0;
        moved = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (poke && (cyc == 3 || cyc == 6)) begin
                start = 1'b1;
                bcd_in = 8'h99;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (!done && bin_out !== prev) moved = 1'b1;
        end while (!done && cyc < 40);
        start = 1'b0;
        check($sformatf("%s_latency", tag), cyc, exp_lat);
        check($sformatf("%s_busy_cycles", tag), busy_cnt, exp_busy);
        check($sformatf("%s_value", tag), bin_out, exp_val);
        check($sformatf("%s_err", tag), err, exp_err);
        check($sformatf("%s_prev_stable", tag), moved, 0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check($sformatf("%s_single_done", tag), extra, 0);
        check($sformatf("%s_held", tag), bin_out, exp_val);
        $display("conv %s bcd=%h -> bin=%0d latency=%0d", tag, v, bin_out, cyc);
    endtask

    initial begin
        int cyc, nd, last, nbusy;
        logic [7:0] v;
        logic [7:0] sweep [8];
        sweep = '{8'h00, 8'h05, 8'h10, 8'h15, 8'h18, 8'h20, 8'h31, 8'h99};

        rst = 1'b1;
        start = 1'b0;
        bcd_in = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_bin", bin_out, 0);
        check("reset_err", err, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            convert($sformatf("sweep%0d", i), sweep[i], 1'b0, 9, 7, bcd_value(sweep[i]), 1'b0);

        for (int n = 0; n < 32; n++)
            convert($sformatf("rt%0d", n), to_bcd(n), 1'b0, 9, 7, n, 1'b0);

        for (int i = 0; i < 20; i++) begin
            v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            convert($sformatf("rnd%0d", i), v, 1'b0, 9, 7, bcd_value(v), 1'b0);
        end

        convert("ignore_start", 8'h42, 1'b1, 9, 7, 42, 1'b0);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        bcd_in = 8'h77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_bin", bin_out, 0);
        check("midreset_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        nbusy = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nbusy++;
        end
        check("midreset_no_done", nd, 0);
        check("midreset_no_busy", nbusy, 0);
        check("midreset_bin_after", bin_out, 0);
        convert("after_reset", 8'h63, 1'b0, 9, 7, 63, 1'b0);

        // start held high: one conversion every 9 cycles.
        @(negedge clk);
        bcd_in = 8'h12;
        start = 1'b1;
        cyc = 0;
        nd = 0;
        last = 0;
        while (nd < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                check("b2b_value", bin_out, 12);
                if (nd > 0) check("b2b_gap", cyc - last, 9);
                $display("b2b done at cycle %0d bin=%0d", cyc, bin_out);
                last = cyc;
                nd++;
            end
        end
        start = 1'b0;
        check("b2b_count", nd, 3);
        repeat (12) @(negedge clk);
        check("b2b_idle", busy, 0);

`ifdef BCD_ERR_CHECK_EN
        convert("bad_digit", 8'h1A, 1'b0, 2, 0, 0, 1'b1);
        check("bad_digit_err_held", err, 1);
        convert("after_bad", 8'h25, 1'b0, 9, 7, 25, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
